// File: rtl/tour_cmd_seq.sv
// Knight-tour command sequencer: owns the cmd_proc command path while a tour runs,
// turning each one-hot L-move into a vertical leg followed by a horizontal leg.
module tour_cmd_seq #(
  parameter int unsigned NUM_MOVES = 24,
  parameter int unsigned IDX_W     = (NUM_MOVES > 1) ? $clog2(NUM_MOVES) : 1,
  parameter int unsigned FANFARE   = 1,
  parameter logic [7:0]  RESP_DONE = 8'hA5,
  parameter logic [7:0]  RESP_BUSY = 8'h5A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  output logic             clr_cmd_rdy_UART,
  output logic [7:0]       resp,
  output logic             tour_active,
  output logic             tour_done,
  output logic             tour_abort,
  output logic             move_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERT   = 3'd2;
  localparam logic [2:0] ST_WAIT_V = 3'd3;
  localparam logic [2:0] ST_HORZ   = 3'd4;
  localparam logic [2:0] ST_WAIT_H = 3'd5;

  localparam logic [3:0] OP_MOVE = 4'h2;
  localparam logic [3:0] OP_FAN  = 4'h3;
  localparam logic [7:0] HDG_N   = 8'h00;
  localparam logic [7:0] HDG_W   = 8'h3F;
  localparam logic [7:0] HDG_S   = 8'h7F;
  localparam logic [7:0] HDG_E   = 8'hBF;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       move_q, move_d;
  logic             abort_pend_q, abort_pend_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic             err_q, err_d;

  logic [7:0]  v_hdg, h_hdg;
  logic [3:0]  v_sq, h_sq;
  logic        is_last_c, fanfare_c, abort_eff_c;
  logic [15:0] vert_cmd_c, horz_cmd_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      move_q       <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      move_q       <= move_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
      err_q        <= err_d;
    end
  end

  // Split the latched L-move into its vertical and horizontal legs
  always_comb begin
    v_hdg = HDG_N;
    v_sq  = 4'd0;
    h_hdg = HDG_N;
    h_sq  = 4'd0;
    case (move_q)
      8'h01: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
      8'h02: begin v_hdg = HDG_N; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
      8'h04: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
      8'h08: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_W; h_sq = 4'd2; end
      8'h10: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_W; h_sq = 4'd1; end
      8'h20: begin v_hdg = HDG_S; v_sq = 4'd2; h_hdg = HDG_E; h_sq = 4'd1; end
      8'h40: begin v_hdg = HDG_S; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
      8'h80: begin v_hdg = HDG_N; v_sq = 4'd1; h_hdg = HDG_E; h_sq = 4'd2; end
      default: ;
    endcase
  end

  // A UART command arriving alongside the final send_resp still ends the tour
  assign is_last_c   = (idx_q == LAST_IDX);
  assign abort_eff_c = abort_pend_q | cmd_rdy_UART;
  assign fanfare_c   = (FANFARE == 1) || ((FANFARE == 2) && is_last_c);
  assign vert_cmd_c  = {OP_MOVE, v_hdg, v_sq};
  assign horz_cmd_c  = {(fanfare_c ? OP_FAN : OP_MOVE), h_hdg, h_sq};

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    move_d           = move_q;
    abort_pend_d     = abort_pend_q;
    done_d           = 1'b0;
    abort_d          = 1'b0;
    err_d            = 1'b0;
    cmd              = vert_cmd_c;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_BUSY;

    if ((state_q != ST_IDLE) && cmd_rdy_UART) abort_pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        abort_pend_d     = 1'b0;
        if (start_tour) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        move_d = move;
        if ($onehot(move)) begin
          state_d = ST_VERT;
        end else begin
          state_d      = ST_IDLE;
          err_d        = 1'b1;
          abort_d      = 1'b1;
          abort_pend_d = 1'b0;
        end
      end
      ST_VERT: begin
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = ST_WAIT_V;
      end
      ST_WAIT_V: begin
        if (send_resp) state_d = ST_HORZ;
      end
      ST_HORZ: begin
        cmd     = horz_cmd_c;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = ST_WAIT_H;
      end
      ST_WAIT_H: begin
        cmd = horz_cmd_c;
        if (is_last_c || abort_eff_c) resp = RESP_DONE;
        if (send_resp) begin
          if (abort_eff_c) begin
            state_d      = ST_IDLE;
            abort_d      = 1'b1;
            abort_pend_d = 1'b0;
          end else if (is_last_c) begin
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            abort_pend_d = 1'b0;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mv_indx     = idx_q;
  assign tour_active = (state_q != ST_IDLE);
  assign tour_done   = done_q;
  assign tour_abort  = abort_q;
  assign move_err    = err_q;

endmodule
